// File: rtl/dmem_debug_port.sv
// Host-side loader/unloader for nand_cpu: WRITE fills D_MEM, RUN releases the core until halt/timeout, DUMP streams D_MEM back.
// WRITE takes 2 cycles per word, DUMP 3 cycles per word; response beats hold until rsp_ready, commands are taken only in IDLE.
module dmem_debug_port #(
  parameter int          ADDR_W     = 16,
  parameter int          DATA_W     = 16,
  parameter int unsigned MAX_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              cpu_n_rst,
  input  logic              cpu_halt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_RSP
  } state_t;

  localparam logic [63:0] DATA_MAX = (64'd1 << DATA_W) - 64'd1;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // Holds WRITE data, or the words still to send during a DUMP.
  logic [DATA_W-1:0]   data_q, data_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic                rsp_err_q, rsp_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_n_rst   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d = cmd_addr;
          data_d = cmd_data;
          case (cmd_op)
            2'd0: state_d = S_WRITE;
            2'd1: begin
              state_d = S_RUN;
              cnt_d   = 32'd1;
            end
            2'd2: begin
              if (cmd_data == '0) begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_last_d  = 1'b1;
                rsp_err_d   = 1'b0;
              end else begin
                state_d = S_DUMP_RD;
              end
            end
            default: begin
              state_d     = S_RSP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_last_d  = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end

      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        state_d   = S_IDLE;
      end

      S_RUN: begin
        cpu_n_rst = 1'b1;
        // Halt wins over a coincident timeout.
        if (cpu_halt || (cnt_q >= MAX_CYCLES)) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ({32'd0, cnt_q} > DATA_MAX) ? '1 : cnt_q[DATA_W-1:0];
          rsp_last_d  = 1'b1;
          rsp_err_d   = !cpu_halt;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_DUMP_RD: begin
        mem_addr = addr_q;
        state_d  = S_DUMP_WAIT;
      end

      S_DUMP_WAIT: begin
        // First cycle here sees the synchronous read data; afterwards wait for the handshake.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_rdata;
          rsp_last_d  = (data_q == DATA_W'(1));
          rsp_err_d   = 1'b0;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          addr_d      = addr_q + ADDR_W'(1);
          data_d      = data_q - DATA_W'(1);
          state_d     = rsp_last_q ? S_IDLE : S_DUMP_RD;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_d = (state_d == S_IDLE);

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_debug_port.sv
// Directed bench for dmem_debug_port: D_MEM model plus a stand-in core that runs a count_to program.
module tb_dmem_debug_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        cpu_n_rst;
  logic        cpu_halt;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mem [0:65535];
  int          hi_cnt = 0;
  int          last_len = 0;
  bit          never_halt = 1'b0;
  logic [15:0] exp_q [$];
  logic [15:0] bd;
  bit          bl, be, bok;

  always #5 clk = ~clk;

  dmem_debug_port #(.ADDR_W(16), .DATA_W(16), .MAX_CYCLES(20)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .cpu_n_rst(cpu_n_rst), .cpu_halt(cpu_halt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Stand-in count_to core: in run cycle k (k=1..N, N=mem[0]) it writes mem[k]=k, halts in cycle N+2.
  assign cpu_halt = cpu_n_rst && !never_halt && (hi_cnt == int'(mem[0]) + 1);

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (cpu_n_rst && hi_cnt < int'(mem[0])) mem[16'(hi_cnt + 1)] <= 16'(hi_cnt + 1);
    mem_rdata <= mem[mem_addr];
    hi_cnt    <= cpu_n_rst ? hi_cnt + 1 : 0;
    if (cpu_n_rst) last_len <= hi_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns at the negedge after the consuming edge; checks hold-stability while stalled.
  task automatic get_beat(input bit stall);
    bit          held;
    logic [15:0] hd;
    bit          hl;
    held = 1'b0;
    hd   = '0;
    hl   = 1'b0;
    bok  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (rsp_valid && held) begin
        check("stall_data", 32'(rsp_data), 32'(hd));
        check("stall_last", 32'(rsp_last), 32'(hl));
      end
      rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        bd  = rsp_data;
        bl  = rsp_last;
        be  = rsp_err;
        bok = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        break;
      end
      if (rsp_valid) begin
        held = 1'b1;
        hd   = rsp_data;
        hl   = rsp_last;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("beat_seen", 32'(bok), 32'd1);
  endtask

  task automatic do_dump(input logic [15:0] addr, input logic [15:0] count, input bit stall);
    int nb;
    send_cmd(2'd2, addr, count);
    nb = (count == 0) ? 1 : int'(count);
    for (int i = 0; i < nb; i++) begin
      get_beat(stall);
      if (!bok) return;
      check("dump_data", 32'(bd), 32'(exp_q[i]));
      check("dump_last", 32'(bl), 32'(i == nb - 1));
      check("dump_err", 32'(be), 32'd0);
    end
    check("dump_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_run(input int exp_data, input bit exp_err, input int exp_len);
    send_cmd(2'd1, 16'h0, 16'h0);
    get_beat(1'b0);
    check("run_data", 32'(bd), 32'(exp_data));
    check("run_last", 32'(bl), 32'd1);
    check("run_err", 32'(be), 32'(exp_err));
    check("run_len", 32'(last_len), 32'(exp_len));
    check("run_core_held", 32'(cpu_n_rst), 32'd0);
    check("run_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    #1;
    check("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("cmd_ready_after_edge", 32'(cmd_ready), 32'd1);

    // count_to with N=5: halt in run cycle 7, then dump 6 words from 0.
    send_cmd(2'd0, 16'h0, 16'd5);
    do_run(7, 1'b0, 7);
    exp_q = '{16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    do_dump(16'h0, 16'd6, 1'b0);

    for (int n = 0; n < 10; n++) begin
      send_cmd(2'd0, 16'h0, 16'(n));
      do_run(n + 2, 1'b0, n + 2);
      exp_q.delete();
      if (n == 0) exp_q.push_back(16'd0);
      for (int k = 1; k <= n; k++) exp_q.push_back(16'(k));
      do_dump(16'h1, 16'(n), 1'b0);
    end

    // Random backpressure on a 4-word dump.
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    do_dump(16'h1, 16'd4, 1'b1);

    // Address wrap; also observe the D_MEM write strobe.
    send_cmd(2'd0, 16'hFFFE, 16'h1111);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'hFFFE);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h1111);
    send_cmd(2'd0, 16'hFFFF, 16'h2222);
    send_cmd(2'd0, 16'h0000, 16'h3333);
    exp_q = '{16'h1111, 16'h2222, 16'h3333};
    do_dump(16'hFFFE, 16'd3, 1'b0);

    send_cmd(2'd3, 16'h1234, 16'h5678);
    get_beat(1'b0);
    check("rsv_data", 32'(bd), 32'd0);
    check("rsv_last", 32'(bl), 32'd1);
    check("rsv_err", 32'(be), 32'd1);

    never_halt = 1'b1;
    do_run(20, 1'b1, 20);
    never_halt = 1'b0;

    // Reset during RUN.
    never_halt = 1'b1;
    send_cmd(2'd1, 16'h0, 16'h0);
    repeat (4) @(negedge clk);
    check("run_released", 32'(cpu_n_rst), 32'd1);
    rst = 1'b1;
    #1;
    check("rstrun_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
    check("rstrun_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstrun_mem_we", 32'(mem_we), 32'd0);
    check("rstrun_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    never_halt = 1'b0;
    @(negedge clk);
    check("rstrun_ready_back", 32'(cmd_ready), 32'd1);

    // Reset mid-DUMP: remaining beats dropped.
    send_cmd(2'd0, 16'h0010, 16'h00A1);
    send_cmd(2'd0, 16'h0011, 16'h00A2);
    send_cmd(2'd0, 16'h0012, 16'h00A3);
    send_cmd(2'd2, 16'h0010, 16'd3);
    get_beat(1'b0);
    check("rstdump_first", 32'(bd), 32'h00A1);
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    check("rstdump_second_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rstdump_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstdump_rsp_last", 32'(rsp_last), 32'd0);
    check("rstdump_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstdump_no_beat", 32'(rsp_valid), 32'd0);
    send_cmd(2'd0, 16'h0020, 16'hBEEF);
    exp_q = '{16'hBEEF};
    do_dump(16'h0020, 16'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
